// File: rtl/uart_rx_ctrl_param.sv
// uart_rx_ctrl_param: parametrised UART RX sequencer with per-frame config latch and registered outcome pulses
//   CLK, RST (async, active-low)       oversampling clock and reset
//   RX_IN                              serial line, idle high
//   PAR_EN, TWO_STOP, PRESCALE         frame configuration, latched on IDLE->START
//   strt_glitch, par_err, stp_err      checker results
//   edge_cnt, bit_cnt                  oversample index within bit, bit index within frame
//   dat_samp_en, deser_en              sampler / deserializer enables
//   strt_chk_en, par_chk_en, stop_chk_en  checker enables
//   busy                               frame in progress
//   data_valid, parity_err_o, framing_err_o  one-cycle frame outcome pulses
module uart_rx_ctrl_param #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  TWO_STOP,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  dat_samp_en,
  output logic                  deser_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stop_chk_en,
  output logic                  busy,
  output logic                  data_valid,
  output logic                  parity_err_o,
  output logic                  framing_err_o
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t state;
  logic par_q, two_q, last, chk, p_ok;
  logic [PRESCALE_W-1:0] p_q;
  assign last = edge_cnt == p_q - PRESCALE_W'(1);
  assign chk  = edge_cnt >= p_q - PRESCALE_W'(2);
  // unsupported ratios fall back to x8
  assign p_ok = PRESCALE == PRESCALE_W'(8) || PRESCALE == PRESCALE_W'(16) || PRESCALE == PRESCALE_W'(32);
  assign busy        = state != IDLE;
  assign dat_samp_en = busy;
  assign deser_en    = state == DATA;
  assign strt_chk_en = state == START && chk;
  assign par_chk_en  = state == PARITY && chk;
  assign stop_chk_en = (state == STOP1 || state == STOP2) && chk;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state         <= IDLE;
      edge_cnt      <= '0;
      bit_cnt       <= '0;
      par_q         <= 1'b0;
      two_q         <= 1'b0;
      p_q           <= PRESCALE_W'(8);
      data_valid    <= 1'b0;
      parity_err_o  <= 1'b0;
      framing_err_o <= 1'b0;
    end else begin
      data_valid    <= 1'b0;
      parity_err_o  <= 1'b0;
      framing_err_o <= 1'b0;
      edge_cnt      <= busy && !last ? edge_cnt + 1'b1 : '0;
      bit_cnt       <= busy ? bit_cnt + BIT_CNT_W'(last) : '0;
      // every branch returning to IDLE also clears bit_cnt (edge_cnt wraps on LAST anyway)
      case (state)
        IDLE: if (!RX_IN) begin
          state <= START;
          par_q <= PAR_EN;
          two_q <= TWO_STOP;
          p_q   <= p_ok ? PRESCALE : PRESCALE_W'(8);
        end
        START: if (last) begin
          state <= strt_glitch ? IDLE : DATA;
          if (strt_glitch) bit_cnt <= '0;
        end
        DATA: if (last && bit_cnt == BIT_CNT_W'(DATA_WIDTH)) state <= par_q ? PARITY : STOP1;
        PARITY: if (last) begin
          state        <= par_err ? IDLE : STOP1;
          parity_err_o <= par_err;
          if (par_err) bit_cnt <= '0;
        end
        STOP1: if (last) begin
          state         <= stp_err || !two_q ? IDLE : STOP2;
          framing_err_o <= stp_err;
          data_valid    <= !stp_err && !two_q;
          if (stp_err || !two_q) bit_cnt <= '0;
        end
        STOP2: if (last) begin
          state         <= IDLE;
          framing_err_o <= stp_err;
          data_valid    <= !stp_err;
          bit_cnt       <= '0;
        end
        default: begin
          state    <= IDLE;
          edge_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
endmodule

// File: doc/uart_rx_ctrl_param.md
Name: uart_rx_ctrl_param

Overview:
Parametrised receive controller for the UART RX path, and the successor of the fixed 8-bit, x8-oversampled RX FSM. It owns the edge and bit counters internally and sequences the external sampler, deserializer and start/parity/stop checkers. It adds configurable data width, a runtime oversampling prescale, an optional second stop bit, and per-frame configuration latching. It reports frame outcome as registered pulses: data_valid, parity_err_o and framing_err_o.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
PRESCALE_W, 6, width of PRESCALE input and edge_cnt.
BIT_CNT_W, 4, width of bit_cnt; must hold DATA_WIDTH+3.

Ports:
CLK  in  1  oversampling clock.
RST  in  1  asynchronous, active-low reset.
RX_IN  in  1  serial line, idle high.
PAR_EN  in  1  parity bit present.
TWO_STOP  in  1  two stop bits expected.
PRESCALE  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
strt_glitch  in  1  start checker result, valid while strt_chk_en=1.
par_err  in  1  parity checker result, valid while par_chk_en=1.
stp_err  in  1  stop checker result, valid while stop_chk_en=1.
edge_cnt  out  PRESCALE_W  oversample index within the current bit.
bit_cnt  out  BIT_CNT_W  bit index within the frame (0 = start bit).
dat_samp_en  out  1  sampler enable.
deser_en  out  1  deserializer shift enable.
strt_chk_en, par_chk_en, stop_chk_en  out  1 each  checker enables.
busy  out  1  high in every state except IDLE.
data_valid  out  1  one-cycle pulse: frame accepted.
parity_err_o  out  1  one-cycle pulse: frame dropped on parity error.
framing_err_o  out  1  one-cycle pulse: frame dropped on stop error.

Behaviour:
- Reset: state IDLE. edge_cnt=0, bit_cnt=0, all outputs 0. Latched configuration resets to PAR_EN=0, TWO_STOP=0, prescale 8. Reset asserted mid-frame aborts the frame immediately with no pulse.
- Configuration latch: PAR_EN, TWO_STOP and PRESCALE are captured on the IDLE->START transition and held for the whole frame. Changes mid-frame are ignored. A PRESCALE value outside {8,16,32} is latched as 8.
- Terms: P = latched prescale; LAST = (edge_cnt == P-1); CHK = (edge_cnt >= P-2).
- Counters:
  - Both hold 0 in IDLE.
  - In every other state, edge_cnt increments each cycle and wraps from P-1 to 0.
  - bit_cnt increments when LAST is true.
  - Both clear to 0 on any transition into IDLE.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2 (encoding free; unused encodings go to IDLE).
- IDLE: RX_IN=0 -> START, and the first START cycle has edge_cnt=0.
- START: strt_chk_en=CHK. At LAST: strt_glitch=1 -> IDLE with no pulse; otherwise -> DATA.
- DATA: deser_en=1. At LAST with bit_cnt==DATA_WIDTH: -> PARITY if latched PAR_EN, else -> STOP1.
- PARITY: par_chk_en=CHK. At LAST: par_err=1 -> IDLE and pulse parity_err_o; otherwise -> STOP1.
- STOP1: stop_chk_en=CHK. At LAST:
  - stp_err=1 -> IDLE and pulse framing_err_o.
  - otherwise, latched TWO_STOP=1 -> STOP2.
  - otherwise -> IDLE and pulse data_valid.
- STOP2: stop_chk_en=CHK. At LAST: stp_err=1 -> IDLE and pulse framing_err_o; otherwise -> IDLE and pulse data_valid.
- dat_samp_en = busy. All enables are decoded combinationally from state and counters.
- Outcome pulses are registered: each is high for exactly one cycle, the cycle after the deciding LAST edge, i.e. the first IDLE cycle. At most one of the three pulses fires per frame.
- Back-to-back frames: RX_IN=0 during the first IDLE cycle after a stop decision starts a new frame on the next edge. A pulse from the previous frame may coincide with the new START entry.
- A stop error with RX_IN held low (line break) returns to IDLE and then restarts a frame. No special break handling.

Test Plan:
- Frame timing, P=8, PAR_EN=0, TWO_STOP=0, frame 0xA5 LSB-first, checkers clean -> data_valid pulses once, 80 cycles after the START entry; deser_en is high for exactly 64 cycles.
- Parity path, P=16, PAR_EN=1, par_err=1 at PARITY LAST -> parity_err_o single pulse; STOP1 never entered; data_valid stays 0; counters return to 0.
- Two stop bits with framing error, TWO_STOP=1, stp_err=1 only in STOP2 -> framing_err_o pulses after 11 bit periods (P=8: 88 cycles); no data_valid.
- Start glitch, RX_IN low for 2 cycles then high, strt_glitch=1 -> return to IDLE after P cycles, no outcome pulse, busy drops.
- Config latch, P=32 latched, then PRESCALE switched to 8 and PAR_EN toggled mid-frame -> frame still uses 32 cycles per bit and the original parity setting. Separately, PRESCALE=12 -> behaves as 8.
- Reset mid-DATA at bit_cnt=4 -> all outputs 0 immediately; after release with RX_IN idle, no pulses and the state stays IDLE. Also DATA_WIDTH=5 build: data_valid after 7 bit periods.
